// File: rtl/conv_win_addr_gen.sv
// Sliding-window row address generator for a KSIZE x KSIZE convolution over a
// width x height x channel frame; one address per kernel row per window.
module conv_win_addr_gen #(
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 12,
   parameter int KSIZE  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DIM_W-1:0]          width,
   input  logic [DIM_W-1:0]          height,
   input  logic [DIM_W-1:0]          channel,
   input  logic [2:0]                stride,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [KSIZE*ADDR_W-1:0]   addr_rows,
   output logic                      row_end,
   output logic                      channel_end,
   output logic                      img_end,
   output logic                      busy,
   output logic                      done,
   output logic                      cfg_err
);

   localparam int CW = DIM_W + 4;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t              state_r;
   logic [DIM_W-1:0]    width_r, height_r, channel_r;
   logic [2:0]          stride_r;
   logic [ADDR_W-1:0]   row_step_r, frame_r;
   logic [DIM_W-1:0]    col_r, row_r, ch_r;
   logic [ADDR_W-1:0]   addr_r      [KSIZE];
   logic [ADDR_W-1:0]   row_start_r [KSIZE];
   logic [ADDR_W-1:0]   ch_start_r  [KSIZE];
   logic                out_valid_r, row_end_r, channel_end_r, img_end_r;
   logic                busy_r, done_r, cfg_err_r;

   logic                cfg_ok_s;
   logic [ADDR_W-1:0]   off_s [KSIZE];
   logic [ADDR_W-1:0]   acc_s;
   logic [DIM_W-1:0]    nxt_col_s, nxt_row_s, nxt_ch_s;
   logic [2:0]          first_flags_s, nxt_flags_s;

   // Returns {img_end, channel_end, row_end} for a window; sums are widened so they never wrap.
   function automatic logic [2:0] end_flags(
      input logic [DIM_W-1:0] col, input logic [DIM_W-1:0] row, input logic [DIM_W-1:0] ch,
      input logic [DIM_W-1:0] w,   input logic [DIM_W-1:0] h,   input logic [DIM_W-1:0] c,
      input logic [2:0]       s
   );
      logic re, ce, ie;
      re = (CW'(col) + CW'(s) + CW'(KSIZE)) > CW'(w);
      ce = re && ((CW'(row) + CW'(s) + CW'(KSIZE)) > CW'(h));
      ie = ce && ((CW'(ch) + CW'(1)) == CW'(c));
      return {ie, ce, re};
   endfunction

   // Start-time configuration checks and per-kernel-row offsets (r*width by repeated addition).
   always_comb begin
      cfg_ok_s = (CW'(width) >= CW'(KSIZE)) && (CW'(height) >= CW'(KSIZE)) &&
                 (channel != {DIM_W{1'b0}}) && (stride != 3'd0);
      acc_s = {ADDR_W{1'b0}};
      for (int r = 0; r < KSIZE; r++) begin
         off_s[r] = acc_s;
         acc_s    = acc_s + ADDR_W'(width);
      end
      first_flags_s = end_flags({DIM_W{1'b0}}, {DIM_W{1'b0}}, {DIM_W{1'b0}},
                                width, height, channel, stride);
   end

   // Next window position (col fastest, then row, then channel) and its end flags.
   always_comb begin
      nxt_col_s = col_r;
      nxt_row_s = row_r;
      nxt_ch_s  = ch_r;
      if (!row_end_r) begin
         nxt_col_s = col_r + DIM_W'(stride_r);
      end else if (!channel_end_r) begin
         nxt_col_s = {DIM_W{1'b0}};
         nxt_row_s = row_r + DIM_W'(stride_r);
      end else begin
         nxt_col_s = {DIM_W{1'b0}};
         nxt_row_s = {DIM_W{1'b0}};
         nxt_ch_s  = ch_r + DIM_W'(1);
      end
      nxt_flags_s = end_flags(nxt_col_s, nxt_row_s, nxt_ch_s,
                              width_r, height_r, channel_r, stride_r);
   end

   // Frame FSM; addresses move by stride, row step or frame size, so no multiply per window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         width_r       <= {DIM_W{1'b0}};
         height_r      <= {DIM_W{1'b0}};
         channel_r     <= {DIM_W{1'b0}};
         stride_r      <= 3'd0;
         row_step_r    <= {ADDR_W{1'b0}};
         frame_r       <= {ADDR_W{1'b0}};
         col_r         <= {DIM_W{1'b0}};
         row_r         <= {DIM_W{1'b0}};
         ch_r          <= {DIM_W{1'b0}};
         out_valid_r   <= 1'b0;
         row_end_r     <= 1'b0;
         channel_end_r <= 1'b0;
         img_end_r     <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         cfg_err_r     <= 1'b0;
         for (int r = 0; r < KSIZE; r++) begin
            addr_r[r]      <= {ADDR_W{1'b0}};
            row_start_r[r] <= {ADDR_W{1'b0}};
            ch_start_r[r]  <= {ADDR_W{1'b0}};
         end
      end else begin
         case (state_r)
            IDLE: begin
               done_r    <= 1'b0;
               cfg_err_r <= 1'b0;
               if (start) begin
                  width_r    <= width;
                  height_r   <= height;
                  channel_r  <= channel;
                  stride_r   <= stride;
                  // Configuration-time products, outside the per-window path.
                  row_step_r <= ADDR_W'(width) * ADDR_W'(stride);
                  frame_r    <= ADDR_W'(width) * ADDR_W'(height);
                  busy_r     <= 1'b1;
                  if (cfg_ok_s) begin
                     state_r       <= RUN;
                     out_valid_r   <= 1'b1;
                     col_r         <= {DIM_W{1'b0}};
                     row_r         <= {DIM_W{1'b0}};
                     ch_r          <= {DIM_W{1'b0}};
                     img_end_r     <= first_flags_s[2];
                     channel_end_r <= first_flags_s[1];
                     row_end_r     <= first_flags_s[0];
                     for (int r = 0; r < KSIZE; r++) begin
                        addr_r[r]      <= base_addr + off_s[r];
                        row_start_r[r] <= base_addr + off_s[r];
                        ch_start_r[r]  <= base_addr + off_s[r];
                     end
                  end else begin
                     state_r   <= DONE;
                     done_r    <= 1'b1;
                     cfg_err_r <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (out_valid_r && out_ready) begin
                  if (img_end_r) begin
                     state_r       <= DONE;
                     out_valid_r   <= 1'b0;
                     done_r        <= 1'b1;
                     row_end_r     <= 1'b0;
                     channel_end_r <= 1'b0;
                     img_end_r     <= 1'b0;
                  end else begin
                     col_r         <= nxt_col_s;
                     row_r         <= nxt_row_s;
                     ch_r          <= nxt_ch_s;
                     img_end_r     <= nxt_flags_s[2];
                     channel_end_r <= nxt_flags_s[1];
                     row_end_r     <= nxt_flags_s[0];
                     for (int r = 0; r < KSIZE; r++) begin
                        if (!row_end_r) begin
                           addr_r[r] <= addr_r[r] + ADDR_W'(stride_r);
                        end else if (!channel_end_r) begin
                           row_start_r[r] <= row_start_r[r] + row_step_r;
                           addr_r[r]      <= row_start_r[r] + row_step_r;
                        end else begin
                           ch_start_r[r]  <= ch_start_r[r] + frame_r;
                           row_start_r[r] <= ch_start_r[r] + frame_r;
                           addr_r[r]      <= ch_start_r[r] + frame_r;
                        end
                     end
                  end
               end
            end
            DONE: begin
               state_r   <= IDLE;
               busy_r    <= 1'b0;
               done_r    <= 1'b0;
               cfg_err_r <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
               cfg_err_r   <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < KSIZE; g++) begin : g_rows
      assign addr_rows[g*ADDR_W +: ADDR_W] = addr_r[g];
   end

   assign out_valid   = out_valid_r;
   assign row_end     = row_end_r;
   assign channel_end = channel_end_r;
   assign img_end     = img_end_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_conv_win_addr_gen.sv
// Scoreboard bench for conv_win_addr_gen: stimulus pushes expected windows, a
// negedge monitor checks every presented window against the queue head.
module tb_conv_win_addr_gen;

   localparam int AW = 32;
   localparam int DW = 12;
   localparam int K  = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [DW-1:0]   width = '0, height = '0, channel = '0;
   logic [2:0]      stride = 3'd0;
   logic [AW-1:0]   base_addr = '0;
   logic            out_ready = 1'b1;
   logic            out_valid;
   logic [K*AW-1:0] addr_rows;
   logic            row_end, channel_end, img_end, busy, done, cfg_err;

   int n_cmp = 0;
   int n_bad = 0;
   bit bp_mode = 1'b0;

   typedef struct {
      logic [K*AW-1:0] rows;
      logic [2:0]      fl;   // {row_end, channel_end, img_end}
   } win_t;
   win_t exp_q[$];

   conv_win_addr_gen #(.ADDR_W(AW), .DIM_W(DW), .KSIZE(K)) dut (
      .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
      .channel(channel), .stride(stride), .base_addr(base_addr), .out_ready(out_ready),
      .out_valid(out_valid), .addr_rows(addr_rows), .row_end(row_end),
      .channel_end(channel_end), .img_end(img_end), .busy(busy), .done(done),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_win(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [2:0] fl);
      win_t w;
      w.rows = {a2, a1, a0};
      w.fl   = fl;
      exp_q.push_back(w);
   endtask

   // Direct-formula reference for a whole frame.
   task automatic push_model(input int w, input int h, input int c, input int s,
                             input logic [AW-1:0] base);
      for (int ch = 0; ch < c; ch++)
         for (int row = 0; row + K <= h; row += s)
            for (int col = 0; col + K <= w; col += s) begin
               logic [AW-1:0] b;
               logic re, ce, ie;
               b  = base + AW'(ch * w * h + col);
               re = (col + s + K) > w;
               ce = re && ((row + s + K) > h);
               ie = ce && (ch == c - 1);
               push_win(b + AW'(row * w), b + AW'((row + 1) * w), b + AW'((row + 2) * w),
                        {re, ce, ie});
            end
   endtask

   // Random stall generator, updated clear of the sampling edge.
   always @(posedge clk) begin
      #2;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: every valid cycle must match the queue head; pop on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_window: got rows %h flags %b, expected none",
                     addr_rows, {row_end, channel_end, img_end});
         end else begin
            chk("window", {addr_rows, row_end, channel_end, img_end},
                {exp_q[0].rows, exp_q[0].fl});
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic do_start(input int w, input int h, input int c, input int s,
                           input logic [AW-1:0] base);
      @(posedge clk); #1;
      width = DW'(w); height = DW'(h); channel = DW'(c); stride = 3'(s); base_addr = base;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk({nm, "_done_seen"}, 128'(seen), 128'(1));
      chk({nm, "_queue_drained"}, 128'(exp_q.size()), 128'(0));
      chk({nm, "_done_state"}, {out_valid, busy, cfg_err}, {1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
      chk({nm, "_back_idle"}, {done, busy, out_valid}, 3'b000);
   endtask

   task automatic run_frame(input string nm, input int w, input int h, input int c,
                            input int s, input logic [AW-1:0] base);
      do_start(w, h, c, s, base);
      chk({nm, "_first_valid"}, {out_valid, busy}, 2'b11);
      wait_done(nm);
   endtask

   initial begin
      #23;
      chk("reset_outputs", {out_valid, busy, done, cfg_err, row_end, channel_end, img_end,
                            addr_rows}, '0);
      rst = 1'b0;

      // 5x5x1, stride 1: nine windows
      push_model(5, 5, 1, 1, 32'd0);
      run_frame("w5h5", 5, 5, 1, 1, 32'd0);

      // 8x3x2, stride 3, base 100: hand-computed
      push_win(32'd100, 32'd108, 32'd116, 3'b000);
      push_win(32'd103, 32'd111, 32'd119, 3'b110);
      push_win(32'd124, 32'd132, 32'd140, 3'b000);
      push_win(32'd127, 32'd135, 32'd143, 3'b111);
      run_frame("w8h3c2", 8, 3, 2, 3, 32'd100);

      // Same 5x5 frame under random backpressure
      bp_mode = 1'b1;
      push_model(5, 5, 1, 1, 32'd0);
      run_frame("backpressure", 5, 5, 1, 1, 32'd0);
      bp_mode = 1'b0;

      // Too-narrow frame: error pulse, no windows
      do_start(2, 5, 1, 1, 32'd0);
      chk("cfg_err_pulse", {out_valid, busy, done, cfg_err}, 4'b0111);
      @(posedge clk); #1;
      chk("cfg_err_clear", {out_valid, busy, done, cfg_err}, 4'b0000);

      // Start with junk config during RUN must be ignored
      push_model(5, 5, 1, 1, 32'd0);
      do_start(5, 5, 1, 1, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      width = 12'd2; height = 12'd9; channel = 12'd4; stride = 3'd2; base_addr = 32'd999;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("start_in_run");

      // Reset while window #5 is presented
      push_model(5, 5, 1, 1, 32'd0);
      do_start(5, 5, 1, 1, 32'd0);
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_reset", {out_valid, busy, done, cfg_err, row_end, channel_end, img_end,
                          addr_rows}, '0);
      exp_q.delete();
      #10 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("no_residual", {out_valid, busy}, 2'b00);
      push_model(5, 5, 1, 1, 32'd0);
      run_frame("restart", 5, 5, 1, 1, 32'd0);

      // Address wrap near 2^32
      push_win(32'hFFFF_FFFC, 32'd1, 32'd6, 3'b000);
      push_win(32'hFFFF_FFFE, 32'd3, 32'd8, 3'b111);
      run_frame("wrap", 5, 3, 1, 2, 32'hFFFF_FFFC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/conv_win_addr_gen.md
CONV_WIN_ADDR_GEN -- requirements
Module: conv_win_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, 32, width of every address output.
REQ-002 SHALL have parameter DIM_W, 12, width of width/height/channel configuration inputs.
REQ-003 SHALL have parameter KSIZE, 3, kernel height/width in pixels (legal 1..7); one row address is emitted per kernel row.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a frame, sampled only in IDLE.
REQ-007 SHALL have ports width, height, channel  input  DIM_W each  frame geometry, latched on accepted start.
REQ-008 SHALL have port stride  input  3  window step (1..7, any value, not power-of-two restricted), latched on accepted start.
REQ-009 SHALL have port base_addr  input  ADDR_W  address of pixel (0,0) of channel 0, latched on accepted start.
REQ-010 SHALL have port out_ready  input  1  consumer accepts current window.
REQ-011 SHALL have port out_valid  output  1  window address set is valid.
REQ-012 SHALL have port addr_rows  output  KSIZE*ADDR_W  row r address in bits [r*ADDR_W +: ADDR_W].
REQ-013 SHALL have ports row_end, channel_end, img_end  output  1 each  current window is last in row / in channel / in frame.
REQ-014 SHALL have ports busy, done, cfg_err  output  1 each  frame active / one-cycle completion pulse / one-cycle bad-config pulse.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; busy=1 in RUN and DONE only.
REQ-016 SHALL accept start only in IDLE; start in RUN or DONE SHALL be ignored and SHALL NOT alter latched configuration.
REQ-017 SHALL treat config as invalid if width<KSIZE, height<KSIZE, channel==0 or stride==0; invalid start SHALL go IDLE->DONE, pulse cfg_err and done together, emit no window.
REQ-018 SHALL, on valid start at edge t, enter RUN with out_valid=1 from t+1 presenting window (ch=0,row=0,col=0).
REQ-019 SHALL define window positions col = 0,S,2S,... while col+KSIZE<=width; row likewise against height; channels 0..channel-1; order col fastest, then row, then channel.
REQ-020 SHALL output addr_rows[r] = base_addr + ch*width*height + (row+r)*width + col, modulo 2^ADDR_W.
REQ-021 SHALL compute addresses incrementally (col/row/channel base registers, additions only); no runtime multiplier in the per-window path.
REQ-022 SHALL hold addr_rows and all end flags stable while out_valid=1 and out_ready=0.
REQ-023 SHALL advance to the next window on the edge where out_valid=1 and out_ready=1, with no bubble (next window valid the following cycle).
REQ-024 SHALL assert row_end when col+S+KSIZE>width; channel_end when row_end and row+S+KSIZE>height; img_end when channel_end and ch==channel-1.
REQ-025 SHALL, on acceptance of the img_end window, drop out_valid and enter DONE; DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-026 SHALL evaluate end comparisons at DIM_W+4 bits so col+S+KSIZE never wraps.

Reset
REQ-027 SHALL, on rst assertion, immediately (asynchronously) force IDLE, out_valid=0, busy=0, done=0, cfg_err=0, all end flags=0, addr_rows=0, counters=0.
REQ-028 SHALL, after rst mid-frame, require a new start; no residual window SHALL be emitted.

Verification
REQ-029 SHALL cover W=5,H=5,C=1,S=1,K=3,base=0, out_ready=1 -> 9 windows; #1 rows {0,5,10}; #3 {2,7,12} row_end; #4 {5,10,15}; #9 {12,17,22} with row_end/channel_end/img_end; done at next cycle.
REQ-030 SHALL cover W=8,H=3,C=2,S=3,base=100 -> cols 0,3 only; windows {100,108,116},{103,111,119},{124,132,140},{127,135,143}; channel_end on 2nd and 4th, img_end on 4th.
REQ-031 SHALL cover backpressure: out_ready toggled 0/1 randomly -> sequence identical to REQ-029, outputs stable during every stall cycle.
REQ-032 SHALL cover start with W=2,K=3 -> no out_valid, cfg_err=done=1 for one cycle, back to IDLE; start during RUN ignored.
REQ-033 SHALL cover rst asserted between clock edges in window #5 -> all outputs 0 before next edge; new start restarts at window #1.
REQ-034 SHALL cover base_addr=2^32-4, W=5 -> row addresses wrap modulo 2^32 ({2^32-4,1,6} first window).
